// File: rtl/wb_sram8_ctrl_if.sv
// wb_sram8_ctrl_if: Wishbone classic bus between the m68k bridge (master) and the SRAM controller (slave)
interface wb_sram8_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport master (output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  input  wbs_ack_o, wbs_dat_o);
  modport slave  (input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/wb_sram8_ctrl.sv
// wb_sram8_ctrl: splits 32-bit Wishbone accesses into byte-serial cycles on an 8-bit async SRAM
module wb_sram8_ctrl #(
  parameter int ADDR_W      = 17,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_sram8_ctrl_if.slave    wb,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [7:0]        sram_dq_i,
  output logic              sram_ce_b,
  output logic              sram_oe_b,
  output logic              sram_we_b
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, ACK} state_t;
  localparam logic [3:0] W_LAST = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [ADDR_W-3:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d, rbuf_q, rbuf_d;
  logic [3:0]        pend_q, pend_d, wcnt_q, wcnt_d;
  logic [1:0]        lane_q, lane_d;
  logic              we_q, we_d, abort_q, abort_d, busy;
  logic              unused_adr;

  function automatic logic [1:0] low_lane(input logic [3:0] m);
    return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
  endfunction

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rbuf_d  = rbuf_q;
    pend_d  = pend_q;
    wcnt_d  = wcnt_q;
    lane_d  = lane_q;
    we_d    = we_q;
    abort_d = abort_q;
    unique case (state_q)
      IDLE: if (wb.wbs_cyc_i && wb.wbs_stb_i) begin
        adr_d   = wb.wbs_adr_i[ADDR_W-1:2];
        dat_d   = wb.wbs_dat_i;
        we_d    = wb.wbs_we_i;
        pend_d  = wb.wbs_sel_i;
        lane_d  = low_lane(wb.wbs_sel_i);
        rbuf_d  = '0;
        abort_d = 1'b0;
        state_d = |wb.wbs_sel_i ? SETUP : ACK;
      end
      SETUP: begin
        wcnt_d  = '0;
        abort_d = abort_q | ~wb.wbs_cyc_i;
        state_d = ACCESS;
      end
      ACCESS: begin
        abort_d = abort_q | ~wb.wbs_cyc_i;
        wcnt_d  = wcnt_q + 4'd1;
        if (wcnt_q == W_LAST) begin
          state_d = HOLD;
          if (!we_q) rbuf_d[{lane_q, 3'b000} +: 8] = sram_dq_i;
        end
      end
      HOLD: begin
        pend_d  = pend_q & ~(4'b0001 << lane_q);
        lane_d  = |pend_d ? low_lane(pend_d) : lane_q;
        state_d = abort_q ? IDLE : |pend_d ? SETUP : ACK;
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      rbuf_q  <= '0;
      pend_q  <= '0;
      wcnt_q  <= '0;
      lane_q  <= '0;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rbuf_q  <= rbuf_d;
      pend_q  <= pend_d;
      wcnt_q  <= wcnt_d;
      lane_q  <= lane_d;
      we_q    <= we_d;
      abort_q <= abort_d;
    end
  end

  // ce_b and write data stay asserted from SETUP through HOLD so the strobe edges never race them
  assign busy          = state_q inside {SETUP, ACCESS, HOLD};
  assign sram_ce_b     = ~busy;
  assign sram_we_b     = ~(state_q == ACCESS && we_q);
  assign sram_oe_b     = ~(state_q == ACCESS && !we_q);
  assign sram_dq_oe    = busy && we_q;
  assign sram_addr     = {adr_q, lane_q};
  assign sram_dq_o     = dat_q[{lane_q, 3'b000} +: 8];
  assign wb.wbs_ack_o  = state_q == ACK;
  assign wb.wbs_dat_o  = state_q == ACK ? rbuf_q : '0;
  assign unused_adr    = ^{wb.wbs_adr_i[31:ADDR_W], wb.wbs_adr_i[1:0]};
endmodule
